// File: rtl/bsg_fifo_reorder_issue_sched.sv
// Issue scheduler sharing one reorder FIFO among several requesters: round-robin
// issue tagged with the allocated reorder id, in-order responses steered back by source.
module bsg_fifo_reorder_issue_sched #(
  parameter int num_req_p = 4,
  parameter int els_p     = 16,
  parameter int width_p   = 32,
  parameter int max_out_p = 4,
  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [num_req_p-1:0]         req_v_i,
  input  logic [num_req_p*width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]         req_yumi_o,
  input  logic                         alloc_v_i,
  input  logic [lg_els_lp-1:0]         alloc_id_i,
  output logic                         alloc_yumi_o,
  output logic                         issue_v_o,
  output logic [width_p-1:0]           issue_data_o,
  output logic [lg_els_lp-1:0]         issue_id_o,
  output logic [lg_req_lp-1:0]         issue_src_o,
  input  logic                         issue_ready_i,
  input  logic                         deq_v_i,
  input  logic [width_p-1:0]           deq_data_i,
  output logic                         deq_yumi_o,
  output logic [num_req_p-1:0]         resp_v_o,
  output logic [width_p-1:0]           resp_data_o,
  input  logic [num_req_p-1:0]         resp_yumi_i
);

  localparam int cnt_w_lp = $clog2(max_out_p + 1);
  localparam int occ_w_lp = $clog2(els_p + 1);

  logic [lg_req_lp-1:0] rr_q, rr_d;
  logic [cnt_w_lp-1:0]  cnt_q [num_req_p];
  logic [cnt_w_lp-1:0]  cnt_d [num_req_p];
  logic [lg_req_lp-1:0] idq_mem_q [els_p];
  logic [lg_els_lp-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [occ_w_lp-1:0]  occ_q, occ_d;

  logic [num_req_p-1:0] eligible;
  logic [lg_req_lp-1:0] winner;
  logic [width_p-1:0]   win_data;
  logic [lg_req_lp-1:0] head;
  logic                 qfull, qempty;
  logic                 issue_v_raw, resp_v_raw;
  logic                 grant, pop;

  assign qfull  = (occ_q == occ_w_lp'(els_p));
  assign qempty = (occ_q == '0);

  always_comb begin
    eligible = '0;
    for (int i = 0; i < num_req_p; i++) begin
      eligible[i] = req_v_i[i] & (cnt_q[i] < cnt_w_lp'(max_out_p));
    end
  end

  // Lowest eligible overall, then overridden by the lowest eligible at or above rr.
  always_comb begin
    winner = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      if (eligible[i]) winner = lg_req_lp'(i);
    end
    for (int i = num_req_p - 1; i >= 0; i--) begin
      if (eligible[i] && (lg_req_lp'(i) >= rr_q)) winner = lg_req_lp'(i);
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (winner == lg_req_lp'(i)) win_data = req_data_i[i*width_p +: width_p];
    end
  end

  assign issue_v_raw = alloc_v_i & (|eligible) & ~qfull;
  assign grant       = issue_v_raw & issue_ready_i & ~reset;

  assign head       = idq_mem_q[rd_q];
  assign resp_v_raw = deq_v_i & ~qempty & ~reset;
  assign pop        = resp_v_raw & resp_yumi_i[head];

  assign issue_v_o    = issue_v_raw & ~reset;
  assign issue_data_o = reset ? '0 : win_data;
  assign issue_id_o   = reset ? '0 : alloc_id_i;
  assign issue_src_o  = reset ? '0 : winner;
  assign alloc_yumi_o = grant;
  assign resp_data_o  = reset ? '0 : deq_data_i;
  assign deq_yumi_o   = pop;

  always_comb begin
    req_yumi_o = '0;
    resp_v_o   = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant && (winner == lg_req_lp'(i)))    req_yumi_o[i] = 1'b1;
      if (resp_v_raw && (head == lg_req_lp'(i))) resp_v_o[i]   = 1'b1;
    end
  end

  always_comb begin
    rr_d  = rr_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (grant) begin
      rr_d = (winner == lg_req_lp'(num_req_p - 1)) ? '0 : winner + lg_req_lp'(1);
      wr_d = (wr_q == lg_els_lp'(els_p - 1)) ? '0 : wr_q + lg_els_lp'(1);
    end
    if (pop) begin
      rd_d = (rd_q == lg_els_lp'(els_p - 1)) ? '0 : rd_q + lg_els_lp'(1);
    end
    unique case ({grant, pop})
      2'b10:   occ_d = occ_q + occ_w_lp'(1);
      2'b01:   occ_d = occ_q - occ_w_lp'(1);
      default: occ_d = occ_q;
    endcase
  end

  // A grant and a return for the same requester in one cycle cancel out.
  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant && (winner == lg_req_lp'(i)) && !(pop && (head == lg_req_lp'(i)))) begin
        if (cnt_q[i] < cnt_w_lp'(max_out_p)) cnt_d[i] = cnt_q[i] + cnt_w_lp'(1);
      end else if (pop && (head == lg_req_lp'(i)) && !(grant && (winner == lg_req_lp'(i)))) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - cnt_w_lp'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q  <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      for (int i = 0; i < num_req_p; i++) cnt_q[i] <= '0;
    end else begin
      rr_q  <= rr_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
      for (int i = 0; i < num_req_p; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (grant) idq_mem_q[wr_q] <= winner;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(deq_v_i && qempty))
        else $fatal(1, "deq_v_i asserted with empty requester-id queue");
      assert ((resp_yumi_i & ~resp_v_o) == '0)
        else $fatal(1, "resp_yumi_i asserted without resp_v_o");
      assert (!(qfull && alloc_v_i))
        else $fatal(1, "alloc_v_i with full requester-id queue: depth mismatch");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_fifo_reorder_issue_sched.sv
// Randomized bench: environment models requesters, fabric and reorder FIFO;
// a reference arbiter plus response scoreboard checks the scheduler.
module tb_bsg_fifo_reorder_issue_sched;
  localparam int N    = 4;
  localparam int ELS  = 16;
  localparam int W    = 32;
  localparam int MAXO = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_v_i;
  logic [N*W-1:0] req_data_i;
  logic [N-1:0]   req_yumi_o;
  logic           alloc_v_i;
  logic [3:0]     alloc_id_i;
  logic           alloc_yumi_o;
  logic           issue_v_o;
  logic [W-1:0]   issue_data_o;
  logic [3:0]     issue_id_o;
  logic [1:0]     issue_src_o;
  logic           issue_ready_i;
  logic           deq_v_i;
  logic [W-1:0]   deq_data_i;
  logic           deq_yumi_o;
  logic [N-1:0]   resp_v_o;
  logic [W-1:0]   resp_data_o;
  logic [N-1:0]   resp_yumi_i;

  always #5 clk = ~clk;

  bsg_fifo_reorder_issue_sched #(.num_req_p(N), .els_p(ELS), .width_p(W), .max_out_p(MAXO)) dut (
    .clk(clk), .reset(reset),
    .req_v_i(req_v_i), .req_data_i(req_data_i), .req_yumi_o(req_yumi_o),
    .alloc_v_i(alloc_v_i), .alloc_id_i(alloc_id_i), .alloc_yumi_o(alloc_yumi_o),
    .issue_v_o(issue_v_o), .issue_data_o(issue_data_o), .issue_id_o(issue_id_o),
    .issue_src_o(issue_src_o), .issue_ready_i(issue_ready_i),
    .deq_v_i(deq_v_i), .deq_data_i(deq_data_i), .deq_yumi_o(deq_yumi_o),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i)
  );

  typedef struct packed { logic [1:0] src; logic [W-1:0] data; } sb_t;
  typedef struct packed { logic [3:0] id;  logic [W-1:0] data; } fl_t;

  int vectors = 0;
  int miscompares = 0;

  // reference model: arbitration pointer, outstanding per requester, expected responses in order
  int  rr_m;
  int  cnt_m [N];
  sb_t sb_q [$];

  // environment
  logic [W-1:0] req_q [N][$];
  fl_t          infl [$];
  bit           slot_done [ELS];
  logic [W-1:0] slot_data [ELS];
  int           alloc_ptr, deq_ptr, fifo_cnt;
  bit           in_reset;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit rnd(int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic clear_models();
    rr_m = 0;
    for (int i = 0; i < N; i++) cnt_m[i] = 0;
    sb_q.delete();
    infl.delete();
    for (int i = 0; i < ELS; i++) slot_done[i] = 1'b0;
    alloc_ptr = 0;
    deq_ptr   = 0;
    fifo_cnt  = 0;
  endtask

  task automatic step(input bit rst, input logic [N-1:0] mask,
                      input int p_req, input int p_rdy, input int p_cmp, input int p_yumi);
    int  k, w, j;
    bit  exp_v, gnt;
    @(negedge clk);
    in_reset = rst;
    reset    = rst;
    if (rst) begin
      req_v_i       = '1;
      req_data_i    = {$urandom, $urandom, $urandom, $urandom};
      alloc_v_i     = 1'b1;
      alloc_id_i    = 4'($urandom);
      issue_ready_i = 1'b1;
      deq_v_i       = 1'b1;
      deq_data_i    = $urandom;
      resp_yumi_i   = '0;
      #2;
      chk("rst_ctrl_outputs", 64'({issue_v_o, issue_src_o, issue_id_o, req_yumi_o,
                                    alloc_yumi_o, deq_yumi_o, resp_v_o}), 64'(0));
      chk("rst_issue_data", 64'(issue_data_o), 64'(0));
      chk("rst_resp_data", 64'(resp_data_o), 64'(0));
      clear_models();
      return;
    end
    for (int i = 0; i < N; i++)
      if (mask[i] && req_q[i].size() < 2 && rnd(p_req)) req_q[i].push_back($urandom);
    if (infl.size() > 0 && rnd(p_cmp)) begin
      k = int'($urandom_range(infl.size() - 1));
      slot_done[infl[k].id] = 1'b1;
      slot_data[infl[k].id] = ~infl[k].data;
      infl.delete(k);
    end
    for (int i = 0; i < N; i++) begin
      req_v_i[i] = mask[i] && (req_q[i].size() > 0);
      req_data_i[i*W +: W] = (req_q[i].size() > 0) ? req_q[i][0] : $urandom;
    end
    alloc_v_i     = fifo_cnt < ELS;
    alloc_id_i    = 4'(alloc_ptr);
    issue_ready_i = rnd(p_rdy);
    deq_v_i       = slot_done[deq_ptr];
    deq_data_i    = deq_v_i ? slot_data[deq_ptr] : $urandom;
    resp_yumi_i   = '0;
    #1;
    resp_yumi_i = rnd(p_yumi) ? resp_v_o : '0;
    #1;
    w = -1;
    for (int n = 0; n < N; n++) begin
      j = (rr_m + n) % N;
      if (w < 0 && req_v_i[j] && cnt_m[j] < MAXO) w = j;
    end
    exp_v = alloc_v_i && (w >= 0) && (sb_q.size() < ELS);
    chk("issue_v", 64'(issue_v_o), 64'(exp_v));
    if (exp_v) begin
      chk("issue_src", 64'(issue_src_o), 64'(w));
      chk("issue_id", 64'(issue_id_o), 64'(alloc_ptr));
      chk("issue_data", 64'(issue_data_o), 64'(req_q[w][0]));
    end
    gnt = exp_v && issue_ready_i;
    chk("req_yumi", 64'(req_yumi_o), gnt ? (64'(1) << w) : 64'(0));
    chk("alloc_yumi", 64'(alloc_yumi_o), 64'(gnt));
    if (gnt) begin
      sb_q.push_back({2'(w), ~req_q[w][0]});
      cnt_m[w]++;
      rr_m = (w + 1) % N;
    end
    for (int i = 0; i < N; i++)
      if (req_yumi_o[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
    if (alloc_yumi_o) begin
      infl.push_back({alloc_id_i, issue_data_o});
      alloc_ptr = (alloc_ptr + 1) % ELS;
      fifo_cnt++;
    end
    if (deq_yumi_o) begin
      slot_done[deq_ptr] = 1'b0;
      deq_ptr = (deq_ptr + 1) % ELS;
      fifo_cnt--;
    end
  endtask

  // response monitor: checks steering against the oldest outstanding issue
  initial begin
    sb_t h;
    forever begin
      @(negedge clk);
      #3;
      if (!in_reset) begin
        if (deq_v_i && sb_q.size() > 0) begin
          h = sb_q[0];
          chk("resp_v", 64'(resp_v_o), 64'(1) << h.src);
          chk("resp_data", 64'(resp_data_o), 64'(h.data));
          chk("deq_yumi", 64'(deq_yumi_o), 64'(resp_yumi_i[h.src]));
          if (resp_yumi_i[h.src]) begin
            void'(sb_q.pop_front());
            cnt_m[h.src]--;
          end
        end else begin
          chk("resp_v_idle", 64'(resp_v_o), 64'(0));
          chk("deq_yumi_idle", 64'(deq_yumi_o), 64'(0));
        end
      end
    end
  end

  initial begin
    in_reset = 1'b1;
    reset = 1'b1;
    req_v_i = '0; req_data_i = '0; alloc_v_i = 1'b0; alloc_id_i = '0;
    issue_ready_i = 1'b0; deq_v_i = 1'b0; deq_data_i = '0; resp_yumi_i = '0;
    clear_models();
    repeat (3) step(1'b1, '0, 0, 0, 0, 0);
    // single requester, out-of-order fabric
    repeat (60)  step(1'b0, 4'b0001, 100, 100, 30, 100);
    // round robin with everyone continuously valid
    repeat (40)  step(1'b0, 4'b1111, 100, 100, 100, 100);
    // credit limit on requester 1, then one return at a time
    repeat (20)  step(1'b0, 4'b0010, 100, 100, 0, 100);
    repeat (20)  step(1'b0, 4'b0010, 100, 100, 50, 100);
    // fill every credit and the id queue, then drain
    repeat (40)  step(1'b0, 4'b1111, 100, 100, 0, 100);
    repeat (60)  step(1'b0, 4'b0000, 0, 100, 100, 100);
    // backpressure on the fabric side
    repeat (5)   step(1'b0, 4'b0001, 100, 0, 50, 100);
    repeat (20)  step(1'b0, 4'b0001, 100, 100, 100, 100);
    // random mixes
    for (int c = 0; c < 8; c++) begin
      int pr, pd, pc, py;
      pr = int'($urandom_range(100, 20));
      pd = int'($urandom_range(100, 20));
      pc = int'($urandom_range(100, 10));
      py = int'($urandom_range(100, 20));
      repeat (100) step(1'b0, 4'($urandom_range(15, 1)), pr, pd, pc, py);
    end
    // head-of-line blocking from a slow consumer
    repeat (200) step(1'b0, 4'b1111, 80, 80, 80, 10);
    // reset with requests outstanding
    repeat (8)   step(1'b0, 4'b1111, 100, 100, 0, 100);
    repeat (2)   step(1'b1, '0, 0, 0, 0, 0);
    repeat (150) step(1'b0, 4'b1111, 90, 70, 60, 70);
    repeat (80)  step(1'b0, 4'b0000, 0, 100, 100, 100);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bsg_fifo_reorder_issue_sched.md
Name: bsg_fifo_reorder_issue_sched

Overview:
- Shares one bsg_fifo_reorder_sync among num_req_p requesters.
- Round-robin arbitrates requesters, consumes a reorder id per request, and issues the request tagged with that id to the remote fabric.
- Steers in-order dequeued responses back to the originating requester via an internal requester-id queue.
- Enforces a per-requester outstanding-request limit.

Parameters:
- num_req_p, 4: number of requesters.
- els_p, 16: reorder FIFO depth; also the depth of the internal requester-id queue.
- width_p, 32: request and response data width.
- max_out_p, 4: maximum outstanding requests per requester.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_v_i  in  num_req_p  per-requester request valid.
- req_data_i  in  num_req_p*width_p  per-requester request payload.
- req_yumi_o  out  num_req_p  request consumed.
- alloc_v_i  in  1  reorder FIFO alloc valid.
- alloc_id_i  in  clog2(els_p)  reorder FIFO allocated id.
- alloc_yumi_o  out  1  consume alloc id.
- issue_v_o  out  1  request to fabric valid.
- issue_data_o  out  width_p  granted payload.
- issue_id_o  out  clog2(els_p)  reorder id tag, equal to alloc_id_i.
- issue_src_o  out  clog2(num_req_p)  granted requester index.
- issue_ready_i  in  1  fabric ready.
- deq_v_i  in  1  reorder FIFO dequeue valid.
- deq_data_i  in  width_p  reorder FIFO dequeue data.
- deq_yumi_o  out  1  consume dequeued entry.
- resp_v_o  out  num_req_p  per-requester response valid, one-hot or zero.
- resp_data_o  out  width_p  response data, shared bus.
- resp_yumi_i  in  num_req_p  requester accepts response.

Behaviour:
- Reset state: rr pointer=0, all outstanding counters=0, id queue empty. While reset is high, all outputs are 0. A reset asserted mid-operation discards the queue and counters; in-flight responses are the environment's problem.
- Eligibility: eligible[i] = req_v_i[i] & (cnt[i] < max_out_p). Eligibility does not depend on issue_ready_i.
- Issue valid: issue_v_o = alloc_v_i & |eligible & ~qfull.
- Winner: first eligible index at or after the rr pointer, wrapping. Payload, id and src outputs are combinational from the winner, with zero added latency.
- Grant condition: grant = issue_v_o & issue_ready_i.
- On grant, same cycle:
  - req_yumi_o[winner]=1 and alloc_yumi_o=1.
  - winner is pushed into the id queue.
  - cnt[winner] increments.
  - rr pointer moves to winner+1 mod num_req_p.
- No grant: the rr pointer holds and no yumi is asserted.
- Id queue: circular buffer of els_p entries, each clog2(num_req_p) bits, with rd/wr pointers that wrap at els_p and an occupancy count 0..els_p. qfull = (count==els_p).
- Response steering: head = queue[rd].
  - resp_v_o[head] = deq_v_i & ~qempty; all other bits are 0.
  - resp_data_o = deq_data_i.
  - deq_yumi_o = resp_v_o[head] & resp_yumi_i[head].
  - On deq_yumi_o: pop the queue and decrement cnt[head].
- Simultaneous push and pop: occupancy is unchanged. If the same requester is granted and returned in one cycle, cnt is unchanged.
- Counters: width clog2(max_out_p+1); they never exceed max_out_p or go below 0.
- Responses reach each requester in its issue order; across requesters, global allocation order is preserved.
- Head-of-line blocking: a requester that withholds resp_yumi_i stalls all responses behind it. This is by design.
- Assertions (nonsynth), each fatal:
  - deq_v_i while the queue is empty.
  - resp_yumi_i asserted on a bit whose resp_v_o is 0.
  - qfull while alloc_v_i=1, which indicates a depth mismatch.

Test Plan:
- Single requester: requester 0 sends 8 requests, fabric returns them in reverse order. Required: ids 0..7 issued, resp_v_o[0] delivers data 0..7 in order, cnt[0] returns to 0.
- Round robin: all 4 requesters continuously valid with issue_ready_i=1. Required: grants go 0,1,2,3,0,1 on consecutive cycles.
- Credit limit: max_out_p=2, requester 1 valid, no responses returned. Required: exactly 2 grants, then eligible[1]=0 and issue_v_o=0. One response to requester 1 re-enables a grant on the next cycle.
- Steering: requesters 2 then 3 each issue one request, and the fabric completes 3's before 2's. Required: resp_v_o=4'b0100 first with 2's data, then 4'b1000. Holding resp_yumi_i[2]=0 for 5 cycles stalls requester 3's response.
- Backpressure and simultaneity: issue_ready_i=0 for 3 cycles with requester 0 valid. Required: issue_v_o stays 1, no yumi, rr pointer fixed. When a grant and a return for requester 0 land in the same cycle, cnt[0] is unchanged.
- Reset mid-run: assert reset with 5 requests outstanding. Required: all outputs 0, counters 0, queue empty. After deassertion, the first grant goes to requester 0.
